fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory over a request/grant/response handshake. Fetched instructions are buffered with their PC+4 and presented to IF/ID through a valid/ready interface. Branch and jump redirects flush buffered and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2: maximum fetches in flight plus buffered (legal 2..8).

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- redirect_i  in  1  branch/jump taken; load the fetch PC from redirect_pc_i and flush.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced to 00).
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address (fetch PC).
- imem_gnt_i  in  1  memory accepts the request this cycle (qualified by imem_req_o).
- imem_rvalid_i  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata_i  in  32  response instruction word.
- out_valid_o  out  1  out_inst_o and out_pc4_o are valid.
- out_ready_i  in  1  IF/ID accepts this cycle (deasserted on stall).
- out_pc4_o  out  32  PC+4 of the presented instruction.
- out_inst_o  out  32  presented instruction.

## Operation
- State: fetch PC fpc; `running` flop; outstanding counter osd (0..DEPTH); drop counter drp (0..DEPTH); pending-PC FIFO (DEPTH entries, holds the PC of each granted request); output buffer FIFO (DEPTH entries of {pc4, inst}); buffer count bcnt.
- pop = out_valid_o & out_ready_i. total = osd + bcnt.
- imem_req_o = running & ~redirect_i & (total - pop < DEPTH). imem_addr_o = fpc.
- Grant (imem_req_o & imem_gnt_i): push fpc onto the pending-PC FIFO, osd+1, fpc <= fpc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Response (imem_rvalid_i, osd > 0): pop the pending-PC FIFO, osd-1. If drp > 0, discard the response and decrement drp. Otherwise push {pc+4, imem_rdata_i} into the output buffer.
- A response with osd == 0 is a protocol violation and is ignored.
- out_valid_o = bcnt != 0; outputs come from the buffer head; pop removes the head.
- Redirect (wins over every other event in the same cycle):
  - fpc <= {redirect_pc_i[31:2], 2'b00}.
  - The output buffer is cleared; any pop that cycle is ignored by IF/ID by construction (IF/ID is flushed too).
  - No request is issued (imem_req_o forced low).
  - drp <= osd - (imem_rvalid_i ? 1 : 0). A response arriving in the redirect cycle is discarded and decrements osd.
  - Redirect while drp > 0 adds the still-undropped outstanding count, i.e. drp <= osd minus this cycle's response.
- Handshake: once imem_req_o is high and imem_gnt_i is low, imem_req_o and imem_addr_o stay stable until grant. A redirect may withdraw the request.

## Timing
- Reset (async, immediate): fpc = RESET_PC, running = 0, osd = drp = bcnt = 0, FIFOs empty. Outputs: imem_req_o = 0, imem_addr_o = RESET_PC, out_valid_o = 0, out_pc4_o = 0, out_inst_o = 0.
- running sets on the first rising edge after rst_n_i deasserts; imem_req_o can assert from the following cycle.
- Latency: grant at edge N, earliest response sampled at edge N+1, out_valid_o high after edge N+1. Minimum request-to-output is 2 edges.
- Throughput: with 1-cycle memory, always granting, and out_ready_i held high, one instruction per cycle at DEPTH >= 2.
- Full: total == DEPTH with no pop means imem_req_o = 0. A pop in the same cycle re-enables the request combinationally.
- Empty: out_valid_o = 0; out_pc4_o/out_inst_o hold their last values and are don't-care.

## Test plan
- Reset, RESET_PC=0, 1-cycle memory (mem[i] = 32'hA000_0000 + i), gnt=1, out_ready=1 -> out_valid_o first high 2 cycles after the first request; then pc4 = 4, 8, 12, … with inst = A000_0000, A000_0001, … every cycle.
- Hold out_ready_i=0 for 10 cycles -> exactly DEPTH=2 grants, then imem_req_o low; output stays pc4=4. On release, pc4 = 4, 8, 12 follow with no gap or loss.
- Memory latency 3 with 2 outstanding, redirect_i to 32'h40 -> both stale responses discarded; next outputs pc4 = 32'h44, 32'h48; no request in the redirect cycle.
- Redirect to 32'h103 -> imem_addr_o = 32'h100. Redirect to 32'hFFFF_FFFC -> output pc4 = 0, and the next imem_addr_o = 0.
- imem_gnt_i low for 5 cycles with the request pending -> imem_req_o high and imem_addr_o constant for all 5 cycles, single grant recorded.
- Drop rst_n_i mid-stream with 2 outstanding (memory reset alongside) -> all outputs take reset values immediately. After release, fetching restarts at RESET_PC and the first output is pc4 = RESET_PC + 4.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's handshakes.
//   redirect_i/redirect_pc_i : branch/jump redirect from the execute side
//   imem_*                   : request/grant/in-order-response instruction memory port
//   out_*                    : valid/ready hand-off toward the IF/ID register
// master = the fetch unit, slave = its environment (memory, IF/ID, redirect source).
interface fetch_unit_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc4_o;
  logic [31:0] out_inst_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, out_ready_i,
    output imem_req_o, imem_addr_o, out_valid_o, out_pc4_o, out_inst_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, out_ready_i,
    input  imem_req_o, imem_addr_o, out_valid_o, out_pc4_o, out_inst_o
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of IF/ID.
// Owns the fetch PC, issues in-order requests to a variable-latency memory,
// buffers returned words with their PC+4 and hands them on over valid/ready.
// A redirect reloads the PC, clears the output buffer and marks every
// in-flight response for discard.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : fetch_unit_if.master (redirect, imem request/response, IF/ID output)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk_i,
  input logic          rst_n_i,
  fetch_unit_if.master bus
);
  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W  = DEPTH[CW:0];
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef logic [PW-1:0] ptr_t;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    if (p == LAST_PTR) r = '0;
    else               r = p + ptr_t'(1);
    return r;
  endfunction

  logic [31:0]   fpc;
  logic          running;
  logic [CW-1:0] osd;
  logic [CW-1:0] drp;
  logic [CW-1:0] bcnt;
  logic [31:0]   pend_mem [DEPTH];
  ptr_t          pend_wr;
  ptr_t          pend_rd;
  logic [63:0]   obuf_mem [DEPTH];
  ptr_t          obuf_wr;
  ptr_t          obuf_rd;

  logic          pop_s;
  logic [CW:0]   total_s;
  logic          req_s;
  logic          grant_s;
  logic          rsp_s;
  logic          push_s;
  logic [31:0]   rsp_pc4_s;

  // Handshake decode; request space accounts for a same-cycle pop.
  always_comb begin
    pop_s     = bus.out_valid_o & bus.out_ready_i;
    total_s   = {1'b0, osd} + {1'b0, bcnt};
    req_s     = running & ~bus.redirect_i & ((total_s - {{CW{1'b0}}, pop_s}) < DEPTH_W);
    grant_s   = req_s & bus.imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_s     = bus.imem_rvalid_i & (osd != '0);
    push_s    = rsp_s & ~bus.redirect_i & (drp == '0);
    rsp_pc4_s = pend_mem[pend_rd] + 32'd4;
  end

  assign bus.imem_req_o  = req_s;
  assign bus.imem_addr_o = fpc;
  assign bus.out_valid_o = (bcnt != '0);
  assign bus.out_pc4_o   = obuf_mem[obuf_rd][63:32];
  assign bus.out_inst_o  = obuf_mem[obuf_rd][31:0];

  // Fetch PC, in-flight bookkeeping and output buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fpc     <= RESET_PC;
      running <= 1'b0;
      osd     <= '0;
      drp     <= '0;
      bcnt    <= '0;
      pend_wr <= '0;
      pend_rd <= '0;
      obuf_wr <= '0;
      obuf_rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pend_mem[i] <= 32'h0000_0000;
        obuf_mem[i] <= 64'h0;
      end
    end else begin
      running <= 1'b1;
      if (grant_s) begin
        pend_mem[pend_wr] <= fpc;
        pend_wr           <= ptr_inc(pend_wr);
      end
      if (rsp_s) begin
        pend_rd <= ptr_inc(pend_rd);
      end
      osd <= osd + CW'(grant_s) - CW'(rsp_s);
      if (bus.redirect_i) begin
        fpc     <= bus.redirect_pc_i & 32'hFFFF_FFFC;
        // Everything still outstanding after this edge is stale.
        drp     <= osd - CW'(rsp_s);
        bcnt    <= '0;
        obuf_rd <= obuf_wr;
      end else begin
        if (grant_s) begin
          fpc <= fpc + 32'd4;
        end
        if (rsp_s && (drp != '0)) begin
          drp <= drp - CW'(1);
        end
        if (push_s) begin
          obuf_mem[obuf_wr] <= {rsp_pc4_s, bus.imem_rdata_i};
          obuf_wr           <= ptr_inc(obuf_wr);
        end
        if (pop_s) begin
          obuf_rd <= ptr_inc(obuf_rd);
        end
        bcnt <= bcnt + CW'(push_s) - CW'(pop_s);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
// Inputs are driven on the falling edge; a behavioural in-order memory with
// programmable latency answers grants; a separate monitor pops expected
// {pc4, inst} pairs whenever IF/ID accepts an output.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct packed { logic [31:0] pc4; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       memq[$];
  logic [31:0] grant_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          pops     = 0;
  int          grants   = 0;
  logic        ready_v  = 1'b0;
  logic        gnt_v    = 1'b1;
  logic        redir_v  = 1'b0;
  logic [31:0] redir_pc_v = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  // Expected stream for n sequential fetches starting at addr.
  task automatic push_seq(input logic [31:0] addr, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      a = addr + 32'(4 * k);
      exp_q.push_back({a + 32'd4, mem_word(a)});
    end
  endtask

  // One clock cycle: drive at negedge, memory answers, log grant at +1.
  task automatic step();
    @(negedge clk);
    bus.out_ready_i   = ready_v;
    bus.imem_gnt_i    = gnt_v;
    bus.redirect_i    = redir_v;
    bus.redirect_pc_i = redir_pc_v;
    if (redir_v) exp_q.delete();
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(memq[0].addr);
      memq.delete(0);
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'hDEAD_BEEF;
    end
    #1;
    if (rst_n && bus.imem_req_o && bus.imem_gnt_i) begin
      mreq_t m;
      m.addr = bus.imem_addr_o;
      m.due  = cyc + lat;
      memq.push_back(m);
      grant_log.push_back(bus.imem_addr_o);
      grants++;
    end
    cyc++;
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (grant_log.size() == 0 && n < 30) begin
      step();
      n++;
    end
    if (grant_log.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no grant within 30 cycles, expected address %h", name, exp_addr);
    end else begin
      check32(name, grant_log.pop_front(), exp_addr);
    end
  endtask

  task automatic wait_osd2(input string name);
    int n;
    n = 0;
    while (memq.size() != 2 && n < 30) begin
      step();
      n++;
    end
    check32(name, 32'(memq.size()), 32'd2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req"},   {31'd0, bus.imem_req_o},  32'd0);
    check32({tag, "_addr"},  bus.imem_addr_o,          RESET_PC);
    check32({tag, "_valid"}, {31'd0, bus.out_valid_o}, 32'd0);
    check32({tag, "_pc4"},   bus.out_pc4_o,            32'd0);
    check32({tag, "_inst"},  bus.out_inst_o,           32'd0);
  endtask

  // Scoreboard monitor: compare every accepted output (redirect cycles are flushed in IF/ID).
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (rst_n && !bus.redirect_i && bus.out_valid_o && bus.out_ready_i) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got pc4 %h inst %h, expected no output", bus.out_pc4_o, bus.out_inst_o);
      end else begin
        e = exp_q.pop_front();
        check32("out_pc4", bus.out_pc4_o, e.pc4);
        check32("out_inst", bus.out_inst_o, e.inst);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int first_req;
    int first_val;
    int p0;
    int n;
    logic [31:0] a0;

    rst_n             = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_gnt_i    = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.out_ready_i   = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) step();
    rst_n = 1'b1;

    // Stall from start: exactly DEPTH grants, then request drops, output holds first word.
    first_req = -1;
    first_val = -1;
    grants    = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (first_req < 0 && bus.imem_req_o) first_req = cyc - 1;
      if (first_val < 0 && bus.out_valid_o) first_val = cyc - 1;
    end
    check32("first_valid_latency", 32'(first_val - first_req), 32'd2);
    check32("stall_grants", 32'(grants), 32'd2);
    check32("stall_req_low", {31'd0, bus.imem_req_o}, 32'd0);
    check32("stall_valid", {31'd0, bus.out_valid_o}, 32'd1);
    check32("stall_pc4", bus.out_pc4_o, 32'h0000_0004);
    check32("stall_inst", bus.out_inst_o, 32'hA000_0000);

    // Release: continuous stream, one instruction per cycle.
    push_seq(RESET_PC, 40);
    ready_v = 1'b1;
    p0 = pops;
    repeat (12) step();
    check32("throughput_pops", 32'(pops - p0), 32'd12);

    // Latency 3, two outstanding, redirect to 0x40.
    lat = 3;
    wait_osd2("osd_before_redirect");
    redir_v    = 1'b1;
    redir_pc_v = 32'h0000_0040;
    step();
    check32("req_in_redirect", {31'd0, bus.imem_req_o}, 32'd0);
    redir_v = 1'b0;
    grant_log.delete();
    exp_q.push_back({32'h0000_0044, 32'hA000_0010});
    exp_q.push_back({32'h0000_0048, 32'hA000_0011});
    push_seq(32'h0000_0048, 18);
    wait_grant("redirect_40_grant", 32'h0000_0040);
    repeat (12) step();

    // Misaligned redirect target is forced to word alignment.
    lat        = 1;
    redir_v    = 1'b1;
    redir_pc_v = 32'h0000_0103;
    step();
    redir_v = 1'b0;
    grant_log.delete();
    push_seq(32'h0000_0100, 10);
    step();
    check32("redirect_103_addr", bus.imem_addr_o, 32'h0000_0100);
    wait_grant("redirect_103_grant", 32'h0000_0100);
    repeat (6) step();

    // Redirect to the top of memory: PC+4 wraps to zero.
    redir_v    = 1'b1;
    redir_pc_v = 32'hFFFF_FFFC;
    step();
    redir_v = 1'b0;
    grant_log.delete();
    exp_q.push_back({32'h0000_0000, 32'hDFFF_FFFF});
    push_seq(32'h0000_0000, 40);
    wait_grant("wrap_grant", 32'hFFFF_FFFC);
    step();
    check32("wrap_next_addr", bus.imem_addr_o, 32'h0000_0000);
    wait_grant("wrap_next_grant", 32'h0000_0000);

    // Grant withheld: request and address must stay stable, then one grant.
    grant_log.delete();
    gnt_v = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.imem_req_o && n < 30);
    check32("gnt_wait_req", {31'd0, bus.imem_req_o}, 32'd1);
    a0 = bus.imem_addr_o;
    for (int i = 0; i < 4; i++) begin
      step();
      check32("gnt_hold_req", {31'd0, bus.imem_req_o}, 32'd1);
      check32("gnt_hold_addr", bus.imem_addr_o, a0);
    end
    gnt_v = 1'b1;
    wait_grant("gnt_hold_grant", a0);
    wait_grant("gnt_hold_next", a0 + 32'd4);

    // Reset mid-stream with two outstanding; memory is reset alongside.
    lat = 3;
    wait_osd2("osd_before_reset");
    @(negedge clk);
    rst_n = 1'b0;
    memq.delete();
    exp_q.delete();
    bus.imem_rvalid_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    #1;
    repeat (3) step();
    lat = 1;
    rst_n = 1'b1;
    grant_log.delete();
    push_seq(RESET_PC, 6);
    wait_grant("restart_grant", RESET_PC);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check32("restart_drain", 32'(exp_q.size()), 32'd0);
    ready_v = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
